// File: rtl/mv_array_sequencer.sv
// Matrix-vector sequencer for an NUM_PROC processor array: CLEAR -> MAC -> DRAIN per pass, then DONE.
// Define MVSEQ_STALL_EN to add fifo_empty_i and hold MAC steps while an active row FIFO is empty.
module mv_array_sequencer #(
  parameter int NUM_PROC = 4,
  parameter int MAX_N    = 16,
  localparam int NW = $clog2(MAX_N + 1),
  localparam int RW = (MAX_N > 1) ? $clog2(MAX_N) : 1,
  localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [NW-1:0]       N_i,
`ifdef MVSEQ_STALL_EN
  input  logic [NUM_PROC-1:0] fifo_empty_i,
`endif
  output logic                busy_o,
  output logic                proc_clr_o,
  output logic [NUM_PROC-1:0] proc_en_o,
  output logic [NUM_PROC-1:0] fifo_pop_o,
  output logic [RW-1:0]       v_idx_o,
  output logic                res_valid_o,
  output logic [PW-1:0]       res_sel_o,
  output logic [RW-1:0]       res_row_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int EW = NW + 1;
  localparam logic [EW-1:0] MAXN_E = EW'(MAX_N);
  localparam logic [EW-1:0] NP_E   = EW'(NUM_PROC);

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [NW-1:0]        base_q, base_d;
  logic [NW-1:0]        stepCnt_q, stepCnt_d;
  logic                 busy_q, busy_d;
  logic                 clr_q, clr_d;
  logic [NUM_PROC-1:0]  en_q, en_d;
  logic [RW-1:0]        vIdx_q, vIdx_d;
  logic                 resValid_q, resValid_d;
  logic [PW-1:0]        resSel_q, resSel_d;
  logic [RW-1:0]        resRow_q, resRow_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [NUM_PROC-1:0]  mask;
  logic                 stall;
  logic [EW-1:0]        nextSel;

  // Lane p is active in the current pass when its global row base_q+p is below N.
  always_comb begin
    mask = '0;
    for (int p = 0; p < NUM_PROC; p++) begin
      mask[p] = (EW'(base_q) + EW'(p)) < EW'(n_q);
    end
  end

`ifdef MVSEQ_STALL_EN
  assign stall = |(fifo_empty_i & mask);
`else
  assign stall = 1'b0;
`endif

  assign nextSel = EW'(resSel_q) + EW'(1);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    base_d     = base_q;
    stepCnt_d  = stepCnt_q;
    clr_d      = 1'b0;
    en_d       = '0;
    vIdx_d     = '0;
    resValid_d = 1'b0;
    resSel_d   = '0;
    resRow_d   = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (N_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (EW'(N_i) > MAXN_E) begin
            err_d = 1'b1;
          end else begin
            n_d     = N_i;
            base_d  = '0;
            state_d = CLEAR;
            clr_d   = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d   = MAC;
        stepCnt_d = '0;
        if (!stall) begin
          en_d      = mask;
          stepCnt_d = NW'(1);
        end
      end
      MAC: begin
        // A stalled step keeps the last broadcast index on v_idx.
        if (stepCnt_q == n_q) begin
          state_d    = DRAIN;
          resValid_d = 1'b1;
          resRow_d   = RW'(base_q);
        end else if (!stall) begin
          en_d      = mask;
          vIdx_d    = RW'(stepCnt_q);
          stepCnt_d = stepCnt_q + NW'(1);
        end else begin
          vIdx_d = vIdx_q;
        end
      end
      DRAIN: begin
        if ((nextSel < NP_E) && ((EW'(base_q) + nextSel) < EW'(n_q))) begin
          resValid_d = 1'b1;
          resSel_d   = PW'(nextSel);
          resRow_d   = RW'(EW'(base_q) + nextSel);
        end else if ((EW'(base_q) + NP_E) < EW'(n_q)) begin
          base_d  = NW'(EW'(base_q) + NP_E);
          state_d = CLEAR;
          clr_d   = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      n_q        <= '0;
      base_q     <= '0;
      stepCnt_q  <= '0;
      busy_q     <= 1'b0;
      clr_q      <= 1'b0;
      en_q       <= '0;
      vIdx_q     <= '0;
      resValid_q <= 1'b0;
      resSel_q   <= '0;
      resRow_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      base_q     <= base_d;
      stepCnt_q  <= stepCnt_d;
      busy_q     <= busy_d;
      clr_q      <= clr_d;
      en_q       <= en_d;
      vIdx_q     <= vIdx_d;
      resValid_q <= resValid_d;
      resSel_q   <= resSel_d;
      resRow_q   <= resRow_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy_o      = busy_q;
  assign proc_clr_o  = clr_q;
  assign proc_en_o   = en_q;
  assign fifo_pop_o  = en_q;
  assign v_idx_o     = vIdx_q;
  assign res_valid_o = resValid_q;
  assign res_sel_o   = resSel_q;
  assign res_row_o   = resRow_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
